// File: rtl/fmadd_issue_arbiter.sv
// fmadd_issue_arbiter: round-robin issue of NREQ requesters onto one in-order FMA pipe, tag FIFO routes results back.
// Define FMADD_ARB_PERF_EN to add saturating perf counters (issue, full, conflict).
module fmadd_issue_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 2,
  parameter int ID_W    = 2,
  parameter int MAX_OUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_rs1_i,
  input  logic [NREQ*WIDTH-1:0] req_rs2_i,
  input  logic [NREQ*WIDTH-1:0] req_rs3_i,
  input  logic [NREQ*5-1:0]     req_rd_i,
  output logic                  fma_valid_in_o,
  output logic [WIDTH-1:0]      fma_a_o,
  output logic [WIDTH-1:0]      fma_b_o,
  output logic [WIDTH-1:0]      fma_c_o,
  input  logic                  fma_valid_out_i,
  input  logic [WIDTH-1:0]      fma_y_i,
  output logic                  wb_valid_o,
  output logic [ID_W-1:0]       wb_id_o,
  output logic [4:0]            wb_rd_o,
  output logic [WIDTH-1:0]      wb_data_o,
  output logic                  busy_o,
  output logic                  err_orphan_o
`ifdef FMADD_ARB_PERF_EN
  ,
  output logic [31:0]           perf_issue_o,
  output logic [31:0]           perf_full_o,
  output logic [31:0]           perf_conflict_o
`endif
);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] FULL = CW'(MAX_OUT);

  logic [ID_W-1:0]   rr_q, rr_d, gnt_id;
  logic [2*NREQ-1:0] rot;
  logic              gnt_v, can_issue, hs, pop, orphan;
  logic [WIDTH-1:0]  sel_a, sel_b, sel_c;
  logic [4:0]        sel_rd;
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ID_W+4:0]   tag_q [MAX_OUT];
  logic              fv_q, wv_q, err_q;
  logic [WIDTH-1:0]  a_q, b_q, c_q, wd_q;
  logic [ID_W-1:0]   wid_q;
  logic [4:0]        wrd_q;

  assign can_issue = cnt_q < FULL || fma_valid_out_i;
  assign hs        = gnt_v && can_issue && !rst;
  assign pop       = fma_valid_out_i && cnt_q != '0;
  assign orphan    = fma_valid_out_i && cnt_q == '0;
  // Rotating the doubled request vector puts the rr pointer at bit 0, so bit k is k steps past the pointer.
  assign rot       = {req_valid_i, req_valid_i} >> rr_q;
  assign rr_d      = hs ? ID_W'((int'(gnt_id) + 1) % NREQ) : rr_q;
  assign wp_d      = hs ? wp_q + PW'(1) : wp_q;
  assign rp_d      = pop ? rp_q + PW'(1) : rp_q;
  assign cnt_d     = cnt_q + CW'(hs) - CW'(pop);

  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) begin
        gnt_v  = 1'b1;
        gnt_id = ID_W'((int'(rr_q) + k) % NREQ);
      end
  end

  always_comb begin
    req_ready_o = '0;
    sel_a       = '0;
    sel_b       = '0;
    sel_c       = '0;
    sel_rd      = '0;
    for (int k = 0; k < NREQ; k++)
      if (gnt_id == ID_W'(k)) begin
        req_ready_o[k] = hs;
        sel_a          = req_rs1_i[k*WIDTH +: WIDTH];
        sel_b          = req_rs2_i[k*WIDTH +: WIDTH];
        sel_c          = req_rs3_i[k*WIDTH +: WIDTH];
        sel_rd         = req_rd_i[k*5 +: 5];
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      fv_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      wv_q  <= 1'b0;
      wid_q <= '0;
      wrd_q <= '0;
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      fv_q  <= hs;
      if (hs) begin
        a_q <= sel_a;
        b_q <= sel_b;
        c_q <= sel_c;
      end
      wv_q <= pop;
      if (pop) begin
        wid_q <= tag_q[rp_q][ID_W+4:5];
        wrd_q <= tag_q[rp_q][4:0];
        wd_q  <= fma_y_i;
      end
      err_q <= err_q || orphan;
    end
  end

  always_ff @(posedge clk)
    if (hs) tag_q[wp_q] <= {gnt_id, sel_rd};

  assign fma_valid_in_o = fv_q;
  assign fma_a_o        = a_q;
  assign fma_b_o        = b_q;
  assign fma_c_o        = c_q;
  assign wb_valid_o     = wv_q;
  assign wb_id_o        = wid_q;
  assign wb_rd_o        = wrd_q;
  assign wb_data_o      = wd_q;
  assign busy_o         = cnt_q != '0 || fv_q;
  assign err_orphan_o   = err_q;

`ifdef FMADD_ARB_PERF_EN
  logic [31:0] pi_q, pf_q, pc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pi_q <= '0;
      pf_q <= '0;
      pc_q <= '0;
    end else begin
      if (hs && pi_q != '1) pi_q <= pi_q + 32'd1;
      if (|req_valid_i && !can_issue && pf_q != '1) pf_q <= pf_q + 32'd1;
      if ($countones(req_valid_i) > 1 && pc_q != '1) pc_q <= pc_q + 32'd1;
    end
  end
  assign perf_issue_o    = pi_q;
  assign perf_full_o     = pf_q;
  assign perf_conflict_o = pc_q;
`endif
endmodule

// File: tb/tb_fmadd_issue_arbiter.sv
// tb_fmadd_issue_arbiter: scenario tasks against a queue-based model of accepts and writebacks, with a latency-3 stub FMA.
module tb_fmadd_issue_arbiter;
  localparam int W = 32, N = 2, IW = 2, MO = 8, L = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W-1:0] rs1 = '0, rs2 = '0, rs3 = '0;
  logic [N*5-1:0] rd = '0;
  logic fvi, fvo, wbv, busy, err;
  logic [W-1:0] fa, fb, fc, fy, wbd;
  logic [IW-1:0] wbid;
  logic [4:0] wbrd;
`ifdef FMADD_ARB_PERF_EN
  logic [31:0] p_issue, p_full, p_conf;
`endif
  int checks = 0, failures = 0, cyc = 0;
  logic stub_on = 1'b1, inj_v = 1'b0;
  logic [W-1:0] inj_y = '0;
  logic [L-1:0] pv;
  logic [W-1:0] py [L];

  typedef struct { int id; int rd; logic [31:0] a, b, c; int cyc; } acc_t;
  typedef struct { int id; int rd; logic [31:0] d; int cyc; } wb_t;
  acc_t accq[$];
  wb_t  wbq[$];

  fmadd_issue_arbiter #(.WIDTH(W), .NREQ(N), .ID_W(IW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rs1_i(rs1), .req_rs2_i(rs2), .req_rs3_i(rs3), .req_rd_i(rd),
    .fma_valid_in_o(fvi), .fma_a_o(fa), .fma_b_o(fb), .fma_c_o(fc),
    .fma_valid_out_i(fvo), .fma_y_i(fy),
    .wb_valid_o(wbv), .wb_id_o(wbid), .wb_rd_o(wbrd), .wb_data_o(wbd),
    .busy_o(busy), .err_orphan_o(err)
`ifdef FMADD_ARB_PERF_EN
    , .perf_issue_o(p_issue), .perf_full_o(p_full), .perf_conflict_o(p_conf)
`endif
  );

  always #5 clk = ~clk;

  function automatic real s2r(input logic [31:0] s);
    return $bitstoreal({s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] fma_ref(input logic [31:0] a, b, c);
    logic [63:0] d;
    d = $realtobits(s2r(a) * s2r(b) + s2r(c));
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(120, 135)), 23'($urandom)};
  endfunction

  // Stub FMA: fixed latency L, cleared while rst is high (its own reset pin is ~rst).
  always @(posedge clk) begin
    if (rst) pv <= '0;
    else pv <= {pv[L-2:0], fvi};
    py[0] <= fma_ref(fa, fb, fc);
    for (int i = 1; i < L; i++) py[i] <= py[i-1];
  end
  assign fvo = stub_on ? pv[L-1] : inj_v;
  assign fy  = stub_on ? py[L-1] : inj_y;

  always @(negedge clk) begin
    #4;
    cyc++;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i])
        accq.push_back('{i, int'(rd[i*5 +: 5]), rs1[i*W +: W], rs2[i*W +: W], rs3[i*W +: W], cyc});
    if (wbv) wbq.push_back('{int'(wbid), int'(wbrd), wbd, cyc});
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; stub_on = 1'b1; inj_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    accq.delete();
    wbq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1;
    repeat (2) @(negedge clk);
    #3;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    checks++; if (fvi !== 1'b0) begin failures++; $display("FAIL reset_fvi got=%b exp=0", fvi); end
    checks++; if (fa !== '0) begin failures++; $display("FAIL reset_fa got=%h exp=0", fa); end
    checks++; if (wbv !== 1'b0) begin failures++; $display("FAIL reset_wbv got=%b exp=0", wbv); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    @(negedge clk);
    rst = 1'b0;
    #3;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL reset_rr_start got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    rs1[31:0] = 32'h4040_0000; rs2[31:0] = 32'h4000_0000; rs3[31:0] = 32'h3F80_0000;
    rd[4:0] = 5'd5; req_valid = 2'b01;
    #3;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #3;
    checks++; if (fvi !== 1'b1) begin failures++; $display("FAIL single_fvi got=%b exp=1", fvi); end
    checks++; if ({fa, fb, fc} !== {32'h4040_0000, 32'h4000_0000, 32'h3F80_0000})
      begin failures++; $display("FAIL single_ops got=%h %h %h exp=40400000 40000000 3f800000", fa, fb, fc); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    repeat (10) @(negedge clk);
    checks++; if (wbq.size() != 1) begin failures++; $display("FAIL single_wb_count got=%0d exp=1", wbq.size()); end
    if (wbq.size() == 1 && accq.size() == 1) begin
      checks++; if (wbq[0].d !== 32'h40E0_0000) begin failures++; $display("FAIL single_data got=%h exp=40e00000", wbq[0].d); end
      checks++; if (wbq[0].id != 0 || wbq[0].rd != 5) begin failures++; $display("FAIL single_tag got=%0d/%0d exp=0/5", wbq[0].id, wbq[0].rd); end
      checks++; if (wbq[0].cyc - accq[0].cyc != 2 + L) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", wbq[0].cyc - accq[0].cyc, 2 + L); end
    end
    #3;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", busy); end
  endtask

  task automatic test_alternate();
    int n[N];
    int tot;
    logic [N-1:0] got;
    do_reset();
    tot = 0; n = '{default: 0};
    for (int i = 0; i < N; i++) begin
      rd[i*5 +: 5] = 5'(i * 8); rs1[i*W +: W] = rnd_fp(); rs2[i*W +: W] = rnd_fp(); rs3[i*W +: W] = rnd_fp();
    end
    for (int t = 0; t < 20 && tot < 6; t++) begin
      req_valid = '1;
      #3;
      got = req_ready;
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (got[i]) begin
          tot++; n[i]++;
          rd[i*5 +: 5] = 5'(i * 8 + n[i]); rs1[i*W +: W] = rnd_fp(); rs2[i*W +: W] = rnd_fp(); rs3[i*W +: W] = rnd_fp();
        end
    end
    req_valid = '0;
    checks++; if (accq.size() != 6) begin failures++; $display("FAIL alt_accepts got=%0d exp=6", accq.size()); end
    for (int k = 0; k < accq.size(); k++) begin
      checks++; if (accq[k].id != k % 2) begin failures++; $display("FAIL alt_grant[%0d] got=%0d exp=%0d", k, accq[k].id, k % 2); end
    end
    repeat (12) @(negedge clk);
    checks++; if (wbq.size() != accq.size()) begin failures++; $display("FAIL alt_wb_count got=%0d exp=%0d", wbq.size(), accq.size()); end
    for (int k = 0; k < accq.size() && k < wbq.size(); k++) begin
      checks++; if (wbq[k].id != accq[k].id || wbq[k].rd != accq[k].rd)
        begin failures++; $display("FAIL alt_wb_order[%0d] got=%0d/%0d exp=%0d/%0d", k, wbq[k].id, wbq[k].rd, accq[k].id, accq[k].rd); end
    end
`ifdef FMADD_ARB_PERF_EN
    checks++; if (p_issue !== 32'd6) begin failures++; $display("FAIL perf_issue got=%0d exp=6", p_issue); end
    checks++; if (p_conf !== 32'd6) begin failures++; $display("FAIL perf_conflict got=%0d exp=6", p_conf); end
`endif
  endtask

  task automatic test_full();
    int acc;
    do_reset();
    stub_on = 1'b0; acc = 0;
    rd[4:0] = 5'd0; rs1[31:0] = rnd_fp(); rs2[31:0] = rnd_fp(); rs3[31:0] = rnd_fp();
    req_valid = 2'b01;
    for (int t = 0; t < 14; t++) begin
      #3;
      if (req_ready[0]) acc++;
      @(negedge clk);
      rd[4:0] = 5'(acc);
    end
    checks++; if (acc != MO) begin failures++; $display("FAIL full_accepts got=%0d exp=%0d", acc, MO); end
    #3;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL full_ready got=%b exp=00", req_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy got=%b exp=1", busy); end
    @(negedge clk);
    inj_v = 1'b1; inj_y = 32'hDEAD_BEEF;
    #3;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL full_pop_accept got=%b exp=01", req_ready); end
    @(negedge clk);
    inj_v = 1'b0;
    #3;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL full_still_full got=%b exp=00", req_ready); end
    checks++; if (wbv !== 1'b1 || wbid !== 2'd0 || wbrd !== 5'd0 || wbd !== 32'hDEAD_BEEF)
      begin failures++; $display("FAIL full_wb got=%b/%0d/%0d/%h exp=1/0/0/deadbeef", wbv, wbid, wbrd, wbd); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL full_err got=%b exp=0", err); end
`ifdef FMADD_ARB_PERF_EN
    checks++; if (p_full == 32'd0) begin failures++; $display("FAIL perf_full got=%0d exp=>0", p_full); end
`endif
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_reset_inflight();
    int acc;
    do_reset();
    acc = 0;
    rd[9:5] = 5'd17; rs1[63:32] = rnd_fp(); rs2[63:32] = rnd_fp(); rs3[63:32] = rnd_fp();
    req_valid = 2'b10;
    for (int t = 0; t < 10 && acc < 3; t++) begin
      #3;
      if (req_ready[1]) acc++;
      @(negedge clk);
    end
    req_valid = '0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #3;
    checks++; if (acc != 3) begin failures++; $display("FAIL rif_accepts got=%0d exp=3", acc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rif_busy got=%b exp=0", busy); end
    checks++; if (fvi !== 1'b0 || wbv !== 1'b0 || fa !== '0) begin failures++; $display("FAIL rif_outputs got=%b/%b/%h exp=0/0/0", fvi, wbv, fa); end
    repeat (8) @(negedge clk);
    checks++; if (wbq.size() != 0) begin failures++; $display("FAIL rif_discard got=%0d exp=0", wbq.size()); end
    stub_on = 1'b0; inj_v = 1'b1; inj_y = 32'h1234_5678;
    @(negedge clk);
    inj_v = 1'b0;
    #3;
    checks++; if (wbv !== 1'b0) begin failures++; $display("FAIL orphan_wbv got=%b exp=0", wbv); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL orphan_err got=%b exp=1", err); end
    repeat (3) @(negedge clk);
    #3;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL orphan_sticky got=%b exp=1", err); end
  endtask

  task automatic test_random();
    logic pend[N];
    int waitg[N];
    logic [N-1:0] got;
    do_reset();
    pend = '{default: 1'b0}; waitg = '{default: 0};
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1; waitg[i] = 0;
          rd[i*5 +: 5] = 5'($urandom); rs1[i*W +: W] = rnd_fp(); rs2[i*W +: W] = rnd_fp(); rs3[i*W +: W] = rnd_fp();
        end
      for (int i = 0; i < N; i++) req_valid[i] = pend[i];
      #3;
      got = req_ready;
      checks++; if ($countones(got) > 1 || (got & ~req_valid) != '0 || (|req_valid && got == '0))
        begin failures++; $display("FAIL rnd_grant cyc=%0d got=%b valid=%b", cyc, got, req_valid); end
      for (int i = 0; i < N; i++)
        if (got[i]) begin
          pend[i] = 1'b0;
          for (int j = 0; j < N; j++)
            if (j != i && pend[j]) begin
              waitg[j]++;
              checks++; if (waitg[j] > N - 1) begin failures++; $display("FAIL rnd_starve req=%0d got=%0d exp<=%0d", j, waitg[j], N - 1); end
            end
        end
      @(negedge clk);
    end
    req_valid = '0;
    repeat (12) @(negedge clk);
    checks++; if (wbq.size() != accq.size()) begin failures++; $display("FAIL rnd_wb_count got=%0d exp=%0d", wbq.size(), accq.size()); end
    for (int k = 0; k < accq.size() && k < wbq.size(); k++) begin
      checks++;
      if (wbq[k].id != accq[k].id || wbq[k].rd != accq[k].rd || wbq[k].d !== fma_ref(accq[k].a, accq[k].b, accq[k].c) ||
          wbq[k].cyc - accq[k].cyc != 2 + L)
        begin failures++; $display("FAIL rnd_wb[%0d] got=%0d/%0d/%h@%0d exp=%0d/%0d/%h@%0d", k, wbq[k].id, wbq[k].rd, wbq[k].d,
          wbq[k].cyc - accq[k].cyc, accq[k].id, accq[k].rd, fma_ref(accq[k].a, accq[k].b, accq[k].c), 2 + L); end
    end
    #3;
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rnd_idle got=%b/%b exp=0/0", busy, err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_full();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
